sap2_alu_unit: RTL and testbench

Arithmetic/logic stage of the SAP-2 datapath, directly downstream of the TMP register. It consumes the accumulator value and the TMP register's ALU-side output, executes one operation per start request, and holds the result in an internal result register. The result is returned to the shared W bus through a tristate driver, and the stage maintains the sign/zero (and optional carry) flags used by the controller for conditional jumps. Multi-bit rotates run one bit per clock under a small FSM.

---
 rtl/sap2_alu_pkg.sv | 48 ++++
 rtl/sap2_alu_core.sv | 67 ++++++
 rtl/sap2_alu_unit.sv | 159 +++++++++++++++
 tb/tb_sap2_alu_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap2_alu_pkg.sv
// sap2_alu_pkg: shared definitions for the SAP-2 ALU stage.
//   - opcode encodings (op_e), FSM state encodings (state_e)
//   - flag bit positions in oFlags: FLAG_S, FLAG_Z, FLAG_C
//   - CarryEn: 1 when the build defines ALU_CARRY_FLAG_EN (carry flag and
//     9-bit rotate-through-carry), 0 otherwise
//   - is_rotate_n(): true for the multi-cycle rotate opcodes
package sap2_alu_pkg;

    localparam int unsigned DataWidth = 8;

    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpAna  = 4'd2,
        OpOra  = 4'd3,
        OpXra  = 4'd4,
        OpCma  = 4'd5,
        OpInr  = 4'd6,
        OpDcr  = 4'd7,
        OpRal  = 4'd8,
        OpRar  = 4'd9,
        OpRaln = 4'd10,
        OpRarn = 4'd11,
        OpNop  = 4'd12
    } op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StExec  = 2'd1,
        StShift = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned FLAG_S = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_C = 2;

`ifdef ALU_CARRY_FLAG_EN
    localparam bit CarryEn = 1'b1;
`else
    localparam bit CarryEn = 1'b0;
`endif

    function automatic logic is_rotate_n(logic [3:0] op);
        return (op == OpRaln) || (op == OpRarn);
    endfunction

endpackage

// File: rtl/sap2_alu_core.sv
// sap2_alu_core: purely combinational operation unit.
//   op_i      opcode (op_e encoding; 10..15 behave as NOP here)
//   a_i, t_i  accumulator and TMP operands
//   c_i       incoming carry (only meaningful with ALU_CARRY_FLAG_EN)
//   result_o  8-bit result, arithmetic mod 256
//   c_o       outgoing carry; forced 0 when ALU_CARRY_FLAG_EN is undefined
// Build option: ALU_CARRY_FLAG_EN selects 9-bit rotate-through-carry for
// RAL/RAR; otherwise rotates are 8-bit circular.
module sap2_alu_core
    import sap2_alu_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic [7:0] a_i,
    input  logic [7:0] t_i,
    input  logic       c_i,
    output logic [7:0] result_o,
    output logic       c_o
);

    logic [8:0] sum;

    always_comb begin
        sum      = '0;
        result_o = a_i;
        c_o      = c_i;   // logic ops, INR, DCR and NOP leave carry alone
        case (op_i)
            OpAdd: begin
                sum      = {1'b0, a_i} + {1'b0, t_i};
                result_o = sum[7:0];
                c_o      = sum[8];
            end
            OpSub: begin
                // Bit 8 of the 9-bit difference is the borrow (a < t).
                sum      = {1'b0, a_i} - {1'b0, t_i};
                result_o = sum[7:0];
                c_o      = sum[8];
            end
            OpAna: result_o = a_i & t_i;
            OpOra: result_o = a_i | t_i;
            OpXra: result_o = a_i ^ t_i;
            OpCma: begin
                result_o = ~a_i;
                c_o      = 1'b0;
            end
            OpInr: result_o = a_i + 8'd1;
            OpDcr: result_o = a_i - 8'd1;
`ifdef ALU_CARRY_FLAG_EN
            OpRal: begin
                result_o = {a_i[6:0], c_i};
                c_o      = a_i[7];
            end
            OpRar: begin
                result_o = {c_i, a_i[7:1]};
                c_o      = a_i[0];
            end
`else
            OpRal: result_o = {a_i[6:0], a_i[7]};
            OpRar: result_o = {a_i[0], a_i[7:1]};
`endif
            default: result_o = a_i;
        endcase
`ifndef ALU_CARRY_FLAG_EN
        c_o = 1'b0;
`endif
    end

endmodule

// File: rtl/sap2_alu_unit.sv
// sap2_alu_unit: SAP-2 ALU stage between the TMP register and the W bus.
//   iClk, iReset   clock, synchronous active-high reset
//   iAcc, iTmp     operands, sampled only when iStart is accepted in IDLE
//   iOp, iStart    opcode and start request (ignored unless IDLE)
//   iEn            drives the result register onto wBus
//   oResult        result register
//   oFlags         {C, Z, S}; C stays 0 unless ALU_CARRY_FLAG_EN is defined
//   oBusy, oDone   busy in EXEC/SHIFT/DONE; oDone marks the DONE cycle
//   wBus           tristate copy of oResult
// Build option: ALU_CARRY_FLAG_EN enables the carry flag and rotates through C.
module sap2_alu_unit
    import sap2_alu_pkg::*;
(
    input  logic       iClk,
    input  logic       iReset,
    input  logic [7:0] iAcc,
    input  logic [7:0] iTmp,
    input  logic [3:0] iOp,
    input  logic       iStart,
    input  logic       iEn,
    output logic [7:0] oResult,
    output logic [2:0] oFlags,
    output logic       oBusy,
    output logic       oDone,
    output tri   [7:0] wBus
);

    state_e     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] tmp_q, tmp_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] result_q, result_d;
    logic       s_q, s_d;
    logic       z_q, z_d;
    logic       c_q, c_d;     // architectural carry flag
    logic       cw_q, cw_d;   // working carry, stepped during rotates
    logic       load_flags;

    logic [3:0] core_op;
    logic [7:0] core_a;
    logic [7:0] core_res;
    logic       core_c_out;

    sap2_alu_core u_core (
        .op_i     (core_op),
        .a_i      (core_a),
        .t_i      (tmp_q),
        .c_i      (cw_q),
        .result_o (core_res),
        .c_o      (core_c_out)
    );

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q  <= StIdle;
            op_q     <= '0;
            acc_q    <= '0;
            tmp_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            s_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            cw_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            tmp_q    <= tmp_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            s_q      <= s_d;
            z_q      <= z_d;
            c_q      <= c_d;
            cw_q     <= cw_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        acc_d      = acc_q;
        tmp_d      = tmp_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        s_d        = s_q;
        z_d        = z_q;
        c_d        = c_q;
        cw_d       = cw_q;
        load_flags = 1'b0;
        core_op    = op_q;
        core_a     = acc_q;

        case (state_q)
            StIdle: begin
                if (iStart) begin
                    op_d  = iOp;
                    acc_d = iAcc;
                    tmp_d = iTmp;
                    cw_d  = c_q;
                    if (is_rotate_n(iOp)) begin
                        result_d = iAcc;
                        cnt_d    = iTmp[2:0];
                        state_d  = StShift;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                result_d   = core_res;
                cw_d       = core_c_out;
                load_flags = 1'b1;
                state_d    = StDone;
            end
            StShift: begin
                // Reuse the single-step rotate on the result register.
                core_op = (op_q == OpRaln) ? OpRal : OpRar;
                core_a  = result_q;
                if (cnt_q == 3'd0) begin
                    load_flags = 1'b1;
                    state_d    = StDone;
                end else begin
                    result_d = core_res;
                    cw_d     = core_c_out;
                    cnt_d    = cnt_q - 3'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Flags are committed on the edge into DONE so they are valid
        // alongside oDone and hold at all other times.
        if (load_flags) begin
            s_d = result_d[7];
            z_d = (result_d == 8'h00);
            c_d = cw_d;
        end
    end

    always_comb begin
        oFlags         = '0;
        oFlags[FLAG_S] = s_q;
        oFlags[FLAG_Z] = z_q;
        oFlags[FLAG_C] = CarryEn ? c_q : 1'b0;
    end

    assign oResult = result_q;
    assign oBusy   = (state_q != StIdle);
    assign oDone   = (state_q == StDone);
    assign wBus    = iEn ? result_q : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_sap2_alu_unit.sv
// Directed bench for sap2_alu_unit with a behavioural reference model.
module tb_sap2_alu_unit;
    import sap2_alu_pkg::*;

    logic       iClk = 1'b0;
    logic       iReset = 1'b1;
    logic [7:0] iAcc = '0;
    logic [7:0] iTmp = '0;
    logic [3:0] iOp = '0;
    logic       iStart = 1'b0;
    logic       iEn = 1'b1;
    logic [7:0] oResult;
    logic [2:0] oFlags;
    logic       oBusy;
    logic       oDone;
    wire  [7:0] w_bus;

    // Released bus floats high so a non-driving DUT is visible.
    pullup (w_bus);

    sap2_alu_unit dut (
        .iClk    (iClk),
        .iReset  (iReset),
        .iAcc    (iAcc),
        .iTmp    (iTmp),
        .iOp     (iOp),
        .iStart  (iStart),
        .iEn     (iEn),
        .oResult (oResult),
        .oFlags  (oFlags),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .wBus    (w_bus)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state, written only by the driver.
    bit         m_check = 1'b0;
    bit         m_active = 1'b0;
    int         m_start = 0;
    int         m_done = 0;
    logic [7:0] m_res = '0;
    logic [2:0] m_flags = '0;
    logic [7:0] m_pend_res = '0;
    logic [2:0] m_pend_flags = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour from plain integer arithmetic; lat is the cycle
    // (relative to acceptance) in which oDone must appear.
    function automatic void model_op(input logic [3:0] op, input logic [7:0] a,
                                     input logic [7:0] t, input bit cin,
                                     output logic [7:0] r, output bit cout, output int lat);
        int ai, ti, n, v;
        bit left;
        ai = int'(a);
        ti = int'(t);
        lat = 2;
        cout = cin;
        r = a;
        n = 1;
        left = 1'b1;
        case (op)
            4'd0: begin r = 8'((ai + ti) % 256); cout = (ai + ti) > 255; end
            4'd1: begin r = 8'((ai - ti + 256) % 256); cout = ai < ti; end
            4'd2: r = a & t;
            4'd3: r = a | t;
            4'd4: r = a ^ t;
            4'd5: begin r = 8'(255 - ai); cout = 1'b0; end
            4'd6: r = 8'((ai + 1) % 256);
            4'd7: r = 8'((ai + 255) % 256);
            4'd9, 4'd11: left = 1'b0;
            default: ;
        endcase
        if (op >= 4'd8 && op <= 4'd11) begin
            if (op >= 4'd10) begin
                n = ti % 8;
                lat = n + 2;
            end
`ifdef ALU_CARRY_FLAG_EN
            v = (cin ? 256 : 0) + ai;
            if (!left) n = 9 - n;
            v = ((v << n) | (v >> (9 - n))) & 511;
            r = 8'(v % 256);
            cout = v >= 256;
`else
            v = ai;
            if (!left) n = 8 - n;
            v = ((v << n) | (v >> (8 - n))) & 255;
            r = 8'(v);
`endif
        end
`ifndef ALU_CARRY_FLAG_EN
        cout = 1'b0;
`endif
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge iClk) begin
        bit in_txn, at_done;
        if (m_check) begin
            in_txn  = m_active && (cyc > m_start) && (cyc <= m_done);
            at_done = m_active && (cyc == m_done);
            check("busy", 32'(oBusy), 32'(in_txn));
            check("done", 32'(oDone), 32'(at_done));
            if (at_done) begin
                check("done_result", 32'(oResult), 32'(m_pend_res));
                check("done_flags", 32'(oFlags), 32'(m_pend_flags));
            end else if (in_txn) begin
                check("flags_hold", 32'(oFlags), 32'(m_flags));
            end else begin
                check("idle_result", 32'(oResult), 32'(m_res));
                check("idle_flags", 32'(oFlags), 32'(m_flags));
                check("wbus", 32'(w_bus), 32'(iEn ? m_res : 8'hFF));
            end
        end
    end

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    // Issue a request in the current (idle) cycle and leave after the
    // acceptance edge with operands scrambled.
    task automatic start_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] t);
        logic [7:0] r;
        bit c;
        int lat;
        model_op(op, a, t, m_flags[FLAG_C], r, c, lat);
        m_pend_res = r;
        m_pend_flags = '0;
        m_pend_flags[FLAG_S] = r[7];
        m_pend_flags[FLAG_Z] = (r == 8'h00);
        m_pend_flags[FLAG_C] = c;
        m_start = cyc;
        m_done = cyc + lat;
        m_active = 1'b1;
        iOp = op;
        iAcc = a;
        iTmp = t;
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        iOp = 4'($urandom);
        iAcc = 8'($urandom);
        iTmp = 8'($urandom);
    endtask

    // chk[0]: pin result to lit_r; chk[1]: pin flags to lit_f.
    task automatic finish_op(input logic [7:0] lit_r, input logic [2:0] lit_f, input bit [1:0] chk);
        while (cyc < m_done) step();
        if (chk[0]) check("lit_result", 32'(oResult), 32'(lit_r));
        if (chk[1]) check("lit_flags", 32'(oFlags), 32'(lit_f));
        step();
        m_res = m_pend_res;
        m_flags = m_pend_flags;
        m_active = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] t,
                          input logic [7:0] lit_r, input logic [2:0] lit_f, input bit [1:0] chk);
        start_op(op, a, t);
        finish_op(lit_r, lit_f, chk);
    endtask

    initial begin
        int t0;
        repeat (3) step();
        iReset = 1'b0;
        m_res = '0;
        m_flags = '0;
        m_check = 1'b1;
        check("rst_wbus", 32'(w_bus), 32'h00);
        check("rst_flags", 32'(oFlags), 32'h0);
        check("rst_busy", 32'(oBusy), 32'h0);
        iEn = 1'b0;
        #1;
        check("rst_wbus_z", 32'(w_bus), 32'hFF);
        step();
        iEn = 1'b1;

        // oDone must land exactly two cycles after acceptance.
        t0 = cyc;
        run_op(OpAdd, 8'h7F, 8'h01, 8'h80, 3'b001, 2'b11);
        check("add_latency", 32'(m_done - t0), 32'd2);
`ifdef ALU_CARRY_FLAG_EN
        run_op(OpAdd, 8'hFF, 8'h01, 8'h00, 3'b110, 2'b11);
`else
        run_op(OpAdd, 8'hFF, 8'h01, 8'h00, 3'b010, 2'b11);
`endif
        run_op(OpSub, 8'h05, 8'h05, 8'h00, 3'b010, 2'b11);
        run_op(OpSub, 8'h03, 8'h05, 8'hFE, 3'b000, 2'b01);
        run_op(OpAna, 8'hF0, 8'h3C, 8'h30, 3'b000, 2'b01);
        run_op(OpOra, 8'hF0, 8'h3C, 8'hFC, 3'b000, 2'b01);
        iEn = 1'b0;
        run_op(OpXra, 8'hF0, 8'h3C, 8'hCC, 3'b000, 2'b01);
        iEn = 1'b1;
        run_op(OpCma, 8'h0F, 8'h00, 8'hF0, 3'b001, 2'b11);
        // Carry is 0 here (CMA cleared it).
        t0 = cyc;
`ifdef ALU_CARRY_FLAG_EN
        run_op(OpRaln, 8'h81, 8'h03, 8'h0A, 3'b000, 2'b11);
`else
        run_op(OpRaln, 8'h81, 8'h03, 8'h0C, 3'b000, 2'b11);
`endif
        check("raln_latency", 32'(m_done - t0), 32'd5);
        t0 = cyc;
        run_op(OpRarn, 8'h81, 8'h00, 8'h81, 3'b001, 2'b11);
        check("rarn0_latency", 32'(m_done - t0), 32'd2);
        run_op(OpInr, 8'hFF, 8'h00, 8'h00, 3'b000, 2'b01);
        run_op(OpDcr, 8'h00, 8'h00, 8'hFF, 3'b000, 2'b01);
        run_op(4'd13, 8'h5A, 8'hA5, 8'h5A, 3'b000, 2'b01);
        run_op(OpRal, 8'h81, 8'h00, 8'h00, 3'b000, 2'b00);
        run_op(OpRar, 8'h81, 8'h00, 8'h00, 3'b000, 2'b00);
        run_op(OpRarn, 8'h3C, 8'h0F, 8'h00, 3'b000, 2'b00);

        // Start pulse during SHIFT must be ignored.
        start_op(OpRarn, 8'h96, 8'h05);
        step();
        iOp = OpAdd;
        iAcc = 8'h11;
        iTmp = 8'h22;
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        finish_op(8'h00, 3'b000, 2'b00);

        // Reset in the second SHIFT cycle aborts with no oDone.
        start_op(OpRaln, 8'h81, 8'h03);
        step();
        iReset = 1'b1;
        step();
        iReset = 1'b0;
        m_active = 1'b0;
        m_res = '0;
        m_flags = '0;
        check("abort_busy", 32'(oBusy), 32'h0);
        check("abort_result", 32'(oResult), 32'h00);
        step();
        run_op(OpAdd, 8'h12, 8'h34, 8'h46, 3'b000, 2'b11);

        // Reset wins over a simultaneous start.
        iReset = 1'b1;
        iStart = 1'b1;
        iOp = OpAdd;
        iAcc = 8'h01;
        iTmp = 8'h01;
        step();
        iReset = 1'b0;
        iStart = 1'b0;
        m_res = '0;
        m_flags = '0;
        step();
        check("rst_start_busy", 32'(oBusy), 32'h0);
        check("rst_start_result", 32'(oResult), 32'h00);
        repeat (3) step();

        m_check = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
